// File: rtl/pl_stage_mem.sv
// Memory-access pipeline stage: turns execute results into byte/half/word/double
// loads and stores on a req/gnt/rvalid data port and registers the write-back result.
module pl_stage_mem #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mvalid,
  input  logic [DATA_WIDTH-1:0] mal,
  input  logic [DATA_WIDTH-1:0] mb,
  input  logic                  mrmem,
  input  logic                  mwmem,
  input  logic [1:0]            msize,
  input  logic                  msext,
  input  logic [4:0]            mrn,
  input  logic                  mwreg,
  output logic                  mstall,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  output logic [7:0]            dmem_be,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic                  wvalid,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [4:0]            wrn,
  output logic                  wwreg,
  output logic                  wmisalign
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t state, state_d;

  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] mb_q;
  logic [1:0]            size_q;
  logic                  sext_q;
  logic                  store_q;
  logic [4:0]            rn_q;
  logic                  wreg_q;

  logic                  is_mem;
  logic                  misalign;
  logic                  accept;
  logic                  go_mem;
  logic                  store_done;
  logic                  load_done;
  logic [7:0]            size_mask;
  logic [5:0]            lane_shift;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] load_val;

  assign is_mem = mrmem | mwmem;

  // Alignment is judged on the incoming address so a bad access never leaves IDLE.
  always_comb begin
    misalign = 1'b0;
    case (msize)
      2'd1:    misalign = mal[0];
      2'd2:    misalign = |mal[1:0];
      2'd3:    misalign = |mal[2:0];
      default: misalign = 1'b0;
    endcase
    if (!is_mem) begin
      misalign = 1'b0;
    end
  end

  assign accept     = (state == IDLE) && mvalid;
  assign go_mem     = accept && is_mem && !misalign;
  assign store_done = (state == REQ) && dmem_gnt && store_q;
  assign load_done  = (state == WAIT) && dmem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    mstall  = 1'b0;
    case (state)
      IDLE: begin
        if (go_mem) begin
          state_d = REQ;
          mstall  = 1'b1;
        end
      end
      REQ: begin
        mstall = !(dmem_gnt && store_q);
        if (dmem_gnt) begin
          state_d = store_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        mstall = !dmem_rvalid;
        if (dmem_rvalid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign lane_shift = {addr_q[2:0], 3'b000};

  always_comb begin
    size_mask = 8'h01;
    case (size_q)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Port outputs come straight from the latched request, so they stay put until gnt.
  always_comb begin
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    dmem_be    = '0;
    if (state == REQ) begin
      dmem_req   = 1'b1;
      dmem_we    = store_q;
      dmem_addr  = {addr_q[DATA_WIDTH-1:3], 3'b000};
      dmem_wdata = mb_q << lane_shift;
      dmem_be    = size_mask << addr_q[2:0];
    end
  end

  assign shifted = dmem_rdata >> lane_shift;

  always_comb begin
    load_val = shifted;
    case (size_q)
      2'd0:    load_val = {{(DATA_WIDTH-8){sext_q & shifted[7]}}, shifted[7:0]};
      2'd1:    load_val = {{(DATA_WIDTH-16){sext_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_val = {{(DATA_WIDTH-32){sext_q & shifted[31]}}, shifted[31:0]};
      default: load_val = shifted;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      mb_q    <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      store_q <= 1'b0;
      rn_q    <= '0;
      wreg_q  <= 1'b0;
    end else if (accept) begin
      addr_q  <= mal;
      mb_q    <= mb;
      size_q  <= msize;
      sext_q  <= msext;
      store_q <= mwmem;
      rn_q    <= mrn;
      wreg_q  <= mwreg;
    end
  end

  // Write-back fields hold their last value; wvalid alone marks a fresh result.
  always_ff @(posedge clk) begin
    if (rst) begin
      wvalid    <= 1'b0;
      wdata     <= '0;
      wrn       <= '0;
      wwreg     <= 1'b0;
      wmisalign <= 1'b0;
    end else begin
      wvalid <= 1'b0;
      if (accept && !go_mem) begin
        wvalid    <= 1'b1;
        wdata     <= misalign ? '0 : mal;
        wrn       <= mrn;
        wwreg     <= mwreg & ~misalign;
        wmisalign <= misalign;
      end else if (store_done) begin
        wvalid    <= 1'b1;
        wdata     <= '0;
        wrn       <= rn_q;
        wwreg     <= wreg_q;
        wmisalign <= 1'b0;
      end else if (load_done) begin
        wvalid    <= 1'b1;
        wdata     <= load_val;
        wrn       <= rn_q;
        wwreg     <= wreg_q;
        wmisalign <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pl_stage_mem.md
# pl_stage_mem

Memory-access pipeline stage that sits directly downstream of the execute stage. It consumes the execute result (ALU value or effective address) and store data, performs byte/half/word/double loads and stores through a request/grant/response data-memory port, and presents a registered result to write-back. It stalls the upstream pipeline while a memory transaction is outstanding. Misaligned accesses are flagged without touching memory.

## Interface
- DATA_WIDTH, 64, datapath width; byte-lane logic is fixed at 8 lanes, so only 64 is supported.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- mvalid  in  1  instruction valid from the EXE/MEM register.
- mal  in  DATA_WIDTH  execute result; the effective address for loads and stores.
- mb  in  DATA_WIDTH  store data, using the low bytes.
- mrmem  in  1  load.
- mwmem  in  1  store; mrmem and mwmem are never both high.
- msize  in  2  access size: 0 = byte, 1 = half, 2 = word, 3 = double.
- msext  in  1  sign-extend load result when high; zero-extend when low.
- mrn  in  5  destination register.
- mwreg  in  1  register write enable.
- mstall  out  1  hold upstream; combinational.
- dmem_req  out  1  memory request.
- dmem_we  out  1  write request.
- dmem_addr  out  DATA_WIDTH  address aligned to 8 bytes, with bits [2:0] = 0.
- dmem_wdata  out  DATA_WIDTH  lane-shifted store data.
- dmem_be  out  8  byte enables.
- dmem_gnt  in  1  request accepted.
- dmem_rvalid  in  1  read data valid.
- dmem_rdata  in  DATA_WIDTH  read data, as the full 8-byte line.
- wvalid  out  1  result valid to write-back; one-cycle pulse per instruction.
- wdata  out  DATA_WIDTH  loaded value or mal; 0 for stores and misaligned accesses.
- wrn  out  5  destination register.
- wwreg  out  1  write enable; forced to 0 on a misaligned access.
- wmisalign  out  1  misaligned-access flag.

## Operation
- The FSM has three states: IDLE, REQ and WAIT.
- **Accept**
  - An instruction is accepted in IDLE when mvalid=1.
  - On acceptance the stage latches mal, mb, msize, msext, mrn, mwreg and the type.
- **Non-memory instruction**
  - Stays in IDLE.
  - Next cycle: wvalid=1, wdata=mal, wrn=mrn, wwreg=mwreg.
- **Misalignment rules**
  - half: addr[0]≠0.
  - word: addr[1:0]≠0.
  - double: addr[2:0]≠0.
  - A misaligned access issues no request and stays in IDLE.
  - Next cycle: wvalid=1, wmisalign=1, wdata=0, wwreg=0.
- **Aligned memory operation**
  - IDLE→REQ.
  - mstall=1 in the accept cycle.
- **REQ state**
  - Drives dmem_req=1, dmem_addr={addr[63:3],3'b0} and dmem_we=store.
  - dmem_be = (size mask 0x01/0x03/0x0F/0xFF) << addr[2:0].
  - dmem_wdata = mb << (8·addr[2:0]).
  - All of these are held stable until dmem_gnt.
  - On gnt with a store: →IDLE, and wvalid=1 next cycle.
  - On gnt with a load: →WAIT.
- **WAIT state**
  - On dmem_rvalid, the loaded value is extracted: shift dmem_rdata right by 8·addr[2:0], truncate to the access size, then sign- or zero-extend per msext.
  - The result is registered into wdata with wvalid=1 next cycle; →IDLE.
- **mstall definition**
  - mstall = (IDLE & mvalid & aligned mem op) | (REQ & ~(gnt & store)) | (WAIT & ~rvalid).
  - Upstream advances when mstall=0.
- **Ignored inputs**
  - dmem_rvalid is ignored outside WAIT.
  - dmem_gnt is ignored outside REQ.
  - mvalid is ignored outside IDLE.
- **Back-to-back issue**: a new instruction may be accepted in the cycle after the previous one completes its final transition.

## Timing
- **Reset values**
  - state=IDLE.
  - wvalid=0, wdata=0, wrn=0, wwreg=0, wmisalign=0.
  - dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0.
- **Reset mid-transaction**: abandons the transaction.
  - The stage drops dmem_req and returns to IDLE.
  - A late dmem_rvalid is ignored.
- **Latencies**
  - Non-memory or misaligned instruction: wvalid 1 cycle after accept, with no stall.
  - Store with dmem_gnt in its first REQ cycle: accept at c0, req/gnt at c1, wvalid at c2; mstall is high in c0 only.
  - Load with gnt at c1 and rvalid at c2: wvalid at c3; mstall is high c0–c1 and low in c2.
- dmem_rvalid in the same cycle as gnt is not possible: rvalid is only sampled in WAIT.
- wvalid is high for exactly one cycle per accepted instruction.

## Test plan
- **Non-memory instruction**: mal=0x1234, mrn=5, mwreg=1, non-mem → next cycle wvalid=1, wdata=0x1234, wrn=5, wwreg=1; mstall=0 throughout.
- **Signed byte load**: lb from 0x1003, msext=1, rdata=0x00000000_80000000, gnt at c1, rvalid at c3 → dmem_addr=0x1000, dmem_be=0x08, wdata=0xFFFF_FFFF_FFFF_FF80 at c4; mstall is high c0–c2.
- **Halfword store with delayed grant**: sh, mb=0xBEEF, addr 0x2006, gnt delayed 3 cycles → dmem_be=0xC0, dmem_wdata=0xBEEF_0000_0000_0000, and req/be/addr held stable until gnt; wvalid one cycle after gnt.
- **Misaligned word load**: lw at 0x3002 → no dmem_req; next cycle wvalid=1, wmisalign=1, wwreg=0, wdata=0; mstall=0.
- **Unsigned word load**: lwu at 0x4004, msext=0, rdata=0x8000_0001_0000_0000 → wdata=0x0000_0000_8000_0001.
- **Reset in WAIT**: rst asserted while in WAIT → dmem_req=0 and wvalid=0; a following rvalid produces no wvalid; the next non-mem instruction completes normally.
